// File: rtl/rf_vote_accumulator_if.sv
// Vote-in / result-out handshake bundle for rf_vote_accumulator.
// Build with RF_VOTE_TIE_FLAG_EN to carry the out_tie flag.
interface rf_vote_accumulator_if #(
  parameter int CLS_W  = 2,
  parameter int VOTE_W = 4
);
  logic              in_valid;
  logic [CLS_W-1:0]  in_class;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [CLS_W-1:0]  out_class;
  logic [VOTE_W-1:0] out_votes;
`ifdef RF_VOTE_TIE_FLAG_EN
  logic              out_tie;
`endif

  modport slave (
    input  in_valid,
    input  in_class,
    output in_ready,
    output out_valid,
    input  out_ready,
    output out_class,
`ifdef RF_VOTE_TIE_FLAG_EN
    output out_tie,
`endif
    output out_votes
  );

  modport master (
    output in_valid,
    output in_class,
    input  in_ready,
    input  out_valid,
    output out_ready,
    input  out_class,
`ifdef RF_VOTE_TIE_FLAG_EN
    input  out_tie,
`endif
    input  out_votes
  );
endinterface

// File: rtl/rf_vote_accumulator.sv
// Random-forest vote accumulator: collect N_TREES votes, scan argmax, hold result.
// Optional tie flag enabled by defining RF_VOTE_TIE_FLAG_EN.
module rf_vote_accumulator #(
  parameter int N_TREES   = 8,
  parameter int N_CLASSES = 4,
  parameter int CLS_W     = 2,
  parameter int VOTE_W    = 4
) (
  input  logic clk,
  input  logic rst_n,
  rf_vote_accumulator_if.slave bus
);

  typedef enum logic [1:0] {
    COLLECT,
    SCAN,
    HOLD
  } state_e;

  state_e            state_q;
  logic [VOTE_W-1:0] cnt_q [N_CLASSES];
  logic [VOTE_W-1:0] tree_q;
  logic [CLS_W-1:0]  idx_q;
  logic [VOTE_W-1:0] best_q;
  logic [CLS_W-1:0]  best_idx_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [CLS_W-1:0]  out_class_q;
  logic [VOTE_W-1:0] out_votes_q;

  logic              accept;
  logic              last_vote;
  logic              last_idx;
  logic              hs;
  logic [VOTE_W-1:0] cur;
  logic              gt;
  logic [VOTE_W-1:0] best_d;
  logic [CLS_W-1:0]  best_idx_d;

`ifdef RF_VOTE_TIE_FLAG_EN
  logic tie_q;
  logic tie_d;
  logic out_tie_q;
`endif

  assign accept    = in_ready_q & bus.in_valid;
  assign last_vote = tree_q == VOTE_W'(N_TREES - 1);
  assign last_idx  = idx_q == CLS_W'(N_CLASSES - 1);
  assign hs        = out_valid_q & bus.out_ready;

  // Strict compare keeps the lowest index on equal counts
  assign cur        = cnt_q[idx_q];
  assign gt         = cur > best_q;
  assign best_d     = gt ? cur : best_q;
  assign best_idx_d = gt ? idx_q : best_idx_q;

`ifdef RF_VOTE_TIE_FLAG_EN
  always_comb begin
    tie_d = tie_q;
    if (gt)
      tie_d = 1'b0;
    else if (cur == best_q && idx_q != best_idx_q)
      tie_d = 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      tree_q      <= '0;
      idx_q       <= '0;
      best_q      <= '0;
      best_idx_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_class_q <= '0;
      out_votes_q <= '0;
      for (int k = 0; k < N_CLASSES; k++)
        cnt_q[k] <= '0;
`ifdef RF_VOTE_TIE_FLAG_EN
      tie_q       <= 1'b0;
      out_tie_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        COLLECT: begin
          if (accept) begin
            // Out-of-range classes still count as a tree
            for (int k = 0; k < N_CLASSES; k++)
              if (bus.in_class == CLS_W'(k))
                cnt_q[k] <= cnt_q[k] + VOTE_W'(1);
            if (last_vote) begin
              tree_q     <= '0;
              state_q    <= SCAN;
              in_ready_q <= 1'b0;
              idx_q      <= '0;
              best_q     <= '0;
              best_idx_q <= '0;
`ifdef RF_VOTE_TIE_FLAG_EN
              tie_q      <= 1'b0;
`endif
            end else begin
              tree_q <= tree_q + VOTE_W'(1);
            end
          end
        end
        SCAN: begin
          best_q     <= best_d;
          best_idx_q <= best_idx_d;
`ifdef RF_VOTE_TIE_FLAG_EN
          tie_q      <= tie_d;
`endif
          if (last_idx) begin
            idx_q       <= '0;
            state_q     <= HOLD;
            out_valid_q <= 1'b1;
            out_class_q <= best_idx_d;
            out_votes_q <= best_d;
`ifdef RF_VOTE_TIE_FLAG_EN
            out_tie_q   <= tie_d;
`endif
          end else begin
            idx_q <= idx_q + CLS_W'(1);
          end
        end
        HOLD: begin
          if (hs) begin
            state_q     <= COLLECT;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            tree_q      <= '0;
            for (int k = 0; k < N_CLASSES; k++)
              cnt_q[k] <= '0;
          end
        end
        default: begin
          state_q     <= COLLECT;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_class = out_class_q;
  assign bus.out_votes = out_votes_q;
`ifdef RF_VOTE_TIE_FLAG_EN
  assign bus.out_tie   = out_tie_q;
`endif

endmodule

// File: tb/tb_rf_vote_accumulator.sv
// Bench for rf_vote_accumulator: 4-class and 3-class instances in lockstep.
// Tie flag checks compile in with RF_VOTE_TIE_FLAG_EN.
module tb_rf_vote_accumulator;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [1:0] in_class;
  logic       out_ready;

  int compared   = 0;
  int mismatched = 0;

  rf_vote_accumulator_if #(.CLS_W(2), .VOTE_W(4)) ia ();
  rf_vote_accumulator_if #(.CLS_W(2), .VOTE_W(4)) ib ();

  assign ia.in_valid  = in_valid;
  assign ia.in_class  = in_class;
  assign ia.out_ready = out_ready;
  assign ib.in_valid  = in_valid;
  assign ib.in_class  = in_class;
  assign ib.out_ready = out_ready;

  rf_vote_accumulator #(
    .N_TREES(8), .N_CLASSES(4), .CLS_W(2), .VOTE_W(4)
  ) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(ia.slave)
  );

  rf_vote_accumulator #(
    .N_TREES(8), .N_CLASSES(3), .CLS_W(2), .VOTE_W(4)
  ) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(ib.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: histogram, then max, first index at max, tie if several at max
  task automatic ref_vote(input int v[8], input int nc,
                          output int cls, output int votes, output int tie);
    int c[4];
    int mx;
    int n_at_max;
    foreach (c[k]) c[k] = 0;
    foreach (v[i]) if (v[i] < nc) c[v[i]]++;
    mx = 0;
    for (int k = 0; k < nc; k++) if (c[k] > mx) mx = c[k];
    cls = -1;
    n_at_max = 0;
    for (int k = 0; k < nc; k++)
      if (c[k] == mx) begin
        n_at_max++;
        if (cls < 0) cls = k;
      end
    votes = mx;
    tie   = (n_at_max > 1) ? 1 : 0;
  endtask

  task automatic send_votes(input int v[8], input bit gaps, input bit keep_valid);
    int n;
    for (int i = 0; i < 8; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
      n = 0;
      while (!ia.in_ready && n < 20) begin
        tick();
        n++;
      end
      chk("in_ready_for_vote", 32'(ia.in_ready), 1);
      in_valid = 1'b1;
      in_class = 2'(v[i]);
      tick();
    end
    in_valid = keep_valid;
    in_class = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_result();
    int lat;
    lat = 0;
    while (!ia.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("latency", 32'(lat), 4);
    chk("valid3_lockstep", 32'(ib.out_valid), 1);
  endtask

  task automatic check_result(string tag, input int v[8]);
    int c4, n4, t4, c3, n3, t3;
    ref_vote(v, 4, c4, n4, t4);
    ref_vote(v, 3, c3, n3, t3);
    chk({tag, "_class4"}, 32'(ia.out_class), 32'(c4));
    chk({tag, "_votes4"}, 32'(ia.out_votes), 32'(n4));
    chk({tag, "_class3"}, 32'(ib.out_class), 32'(c3));
    chk({tag, "_votes3"}, 32'(ib.out_votes), 32'(n3));
`ifdef RF_VOTE_TIE_FLAG_EN
    chk({tag, "_tie4"}, 32'(ia.out_tie), 32'(t4));
    chk({tag, "_tie3"}, 32'(ib.out_tie), 32'(t3));
`else
    if (t4 < 0 || t3 < 0) chk({tag, "_tie_model"}, 32'(t4), 0);
`endif
  endtask

  task automatic handshake(string tag);
    logic [1:0] cls_before;
    logic [3:0] votes_before;
    cls_before   = ia.out_class;
    votes_before = ia.out_votes;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_hs_valid"}, 32'(ia.out_valid), 0);
    chk({tag, "_hs_ready"}, 32'(ia.in_ready), 1);
    chk({tag, "_hs_class_held"}, 32'(ia.out_class), 32'(cls_before));
    chk({tag, "_hs_votes_held"}, 32'(ia.out_votes), 32'(votes_before));
  endtask

  task automatic run_sample(string tag, input int v[8], input bit gaps);
    send_votes(v, gaps, 1'b0);
    wait_result();
    check_result(tag, v);
    repeat ($urandom_range(0, 3)) tick();
    check_result({tag, "_stable"}, v);
    handshake(tag);
  endtask

  task automatic check_reset_state(string tag);
    chk({tag, "_in_ready"},  32'(ia.in_ready), 1);
    chk({tag, "_out_valid"}, 32'(ia.out_valid), 0);
    chk({tag, "_out_class"}, 32'(ia.out_class), 0);
    chk({tag, "_out_votes"}, 32'(ia.out_votes), 0);
    chk({tag, "_out_valid3"}, 32'(ib.out_valid), 0);
`ifdef RF_VOTE_TIE_FLAG_EN
    chk({tag, "_out_tie"}, 32'(ia.out_tie), 0);
`endif
  endtask

  initial begin
    int v[8];
    logic [1:0] cls_hold;
    logic [3:0] votes_hold;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_class  = 2'd0;
    out_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    check_reset_state("reset");

    v = '{2, 2, 2, 2, 2, 2, 2, 2};
    run_sample("all2", v, 1'b0);

    v = '{1, 3, 3, 0, 3, 1, 2, 3};
    run_sample("maj3", v, 1'b0);

    v = '{1, 1, 2, 2, 0, 3, 1, 2};
    run_sample("tie12", v, 1'b1);

    v = '{3, 0, 0, 3, 3, 3, 3, 3};
    run_sample("cls3", v, 1'b0);

    // Hold result with back-pressure while upstream keeps offering votes
    v = '{0, 1, 1, 2, 1, 3, 1, 0};
    send_votes(v, 1'b0, 1'b1);
    wait_result();
    check_result("bp", v);
    cls_hold   = ia.out_class;
    votes_hold = ia.out_votes;
    for (int c = 0; c < 10; c++) begin
      in_class = 2'($urandom_range(0, 3));
      tick();
      chk("bp_in_ready", 32'(ia.in_ready), 0);
      chk("bp_out_valid", 32'(ia.out_valid), 1);
      chk("bp_class", 32'(ia.out_class), 32'(cls_hold));
      chk("bp_votes", 32'(ia.out_votes), 32'(votes_hold));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("bp_hs_valid", 32'(ia.out_valid), 0);
    v = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_sample("after_bp", v, 1'b0);

    // Reset in the middle of the scan
    v = '{2, 2, 2, 1, 1, 2, 3, 3};
    run_sample("pre_rst", v, 1'b0);
    v = '{3, 3, 3, 3, 3, 3, 3, 1};
    send_votes(v, 1'b0, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_reset_state("rst_scan");
    v = '{1, 1, 1, 0, 0, 2, 2, 3};
    run_sample("post_rst_scan", v, 1'b0);

    // Reset while holding a result nobody takes
    v = '{3, 3, 3, 3, 2, 2, 2, 2};
    send_votes(v, 1'b0, 1'b0);
    wait_result();
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_reset_state("rst_hold");
    v = '{2, 0, 2, 0, 2, 1, 3, 2};
    run_sample("post_rst_hold", v, 1'b0);

    for (int s = 0; s < 25; s++) begin
      foreach (v[i]) v[i] = $urandom_range(0, 3);
      run_sample("rand", v, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
